proc_seq: RTL and testbench

PROC_SEQ -- requirements
Module: proc_seq

---
 rtl/proc_seq_if.sv | 26 ++
 rtl/proc_seq.sv | 140 ++++++++++++++
 tb/tb_proc_seq.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_seq_if.sv
// Load/control handshake and processor-side program-RAM write/run signals for proc_seq.
interface proc_seq_if;
  logic        start;
  logic        abort;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [8:0]  p_addr;
  logic        p_wEn;
  logic [31:0] p_wDat;
  logic        p_working;
  logic        busy;
  logic        done;
  logic [9:0]  words;

  modport master (
    output start, abort, ld_valid, ld_data, ld_last,
    input  ld_ready, p_addr, p_wEn, p_wDat, p_working, busy, done, words
  );

  modport slave (
    input  start, abort, ld_valid, ld_data, ld_last,
    output ld_ready, p_addr, p_wEn, p_wDat, p_working, busy, done, words
  );
endinterface

// File: rtl/proc_seq.sv
// Load-then-run sequencer: streams a program into processor RAM, then holds
// the processor working for words+DRAIN cycles and pulses done.
module proc_seq #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned DRAIN = 2
) (
  input logic        clock,
  input logic        rst_n,
  proc_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH + DRAIN + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    RUN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [8:0]      ptr_q, ptr_d;
  logic [8:0]      addr_q, addr_d;
  logic [31:0]     wdat_q, wdat_d;
  logic            wen_q, wen_d;
  logic            work_q, work_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [9:0]      words_q, words_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    wen_d   = 1'b0;
    work_d  = 1'b0;
    done_d  = 1'b0;
    words_d = words_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          ptr_d   = '0;
          words_d = '0;
        end
      end
      LOAD: begin
        // abort wins over a word offered at the same edge
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.ld_valid) begin
          wen_d   = 1'b1;
          addr_d  = ptr_q;
          wdat_d  = bus.ld_data;
          ptr_d   = ptr_q + 9'd1;
          words_d = words_q + 10'd1;
          if (bus.ld_last || (words_q == 10'(DEPTH - 1))) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
          work_d  = 1'b1;
          cnt_d   = CW'(words_q) + CW'(DRAIN);
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            work_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // ready/busy are registered copies of the upcoming state
    ready_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      wen_q   <= 1'b0;
      work_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      words_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      wen_q   <= wen_d;
      work_q  <= work_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      words_q <= words_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ld_ready  = ready_q;
  assign bus.p_addr    = addr_q;
  assign bus.p_wEn     = wen_q;
  assign bus.p_wDat    = wdat_q;
  assign bus.p_working = work_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.words     = words_q;

endmodule

// File: tb/tb_proc_seq.sv
// Self-checking bench for proc_seq: random program words and gaps, scoreboarded
// against write/run/done timing derived from the load-then-run rules.
module tb_proc_seq;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned DRAIN = 2;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  proc_seq_if bus();

  proc_seq #(.DEPTH(DEPTH), .DRAIN(DRAIN)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nchk = 0;
  int nerr = 0;

  // observed activity, sampled mid-cycle
  int          cyc = 0;
  logic [8:0]  wr_addr[$];
  logic [31:0] wr_dat[$];
  int          wr_cyc[$];
  int          work_n = 0;
  int          work_start = 0;
  int          work_end = 0;
  int          runs = 0;
  int          done_n = 0;
  int          done_cyc = 0;
  int          overlap_n = 0;
  logic        work_prev = 1'b0;

  always @(negedge clock) begin
    if (bus.p_wEn === 1'b1) begin
      wr_addr.push_back(bus.p_addr);
      wr_dat.push_back(bus.p_wDat);
      wr_cyc.push_back(cyc);
    end
    if (bus.p_working === 1'b1) begin
      work_n <= work_n + 1;
      if (work_prev !== 1'b1) begin
        work_start <= cyc;
        runs       <= runs + 1;
      end
      work_end <= cyc;
    end
    work_prev <= bus.p_working;
    if (bus.done === 1'b1) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (bus.p_wEn === 1'b1 && bus.p_working === 1'b1) overlap_n <= overlap_n + 1;
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full start/load/run sequence; expectations come from the word list and
  // the cycle at which each word was offered.
  task automatic run_prog(input int n, input int gapfix, input int gaprand,
                          input bit use_last, input bit noisy, input string tag);
    logic [31:0] w[$];
    int ec[$];
    int wb, wnb, rb, db, g, total;
    bit seen;
    total = n + int'(DRAIN);
    wb  = wr_addr.size();
    wnb = work_n;
    rb  = runs;
    db  = done_n;

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_ready_on_load"}, 32'(bus.ld_ready), 1);
    chk({tag, "_busy_on_load"}, 32'(bus.busy), 1);
    chk({tag, "_words_cleared"}, 32'(bus.words), 0);

    for (int i = 0; i < n; i++) begin
      g = (i == 0) ? 0 : gapfix + ((gaprand > 0) ? int'($urandom_range(gaprand, 0)) : 0);
      for (int k = 0; k < g; k++) begin
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'($urandom);
        bus.ld_data  = $urandom;
        if (noisy) bus.start = 1'($urandom);
        tick();
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = $urandom;
      w.push_back(bus.ld_data);
      bus.ld_last  = use_last && (i == n - 1);
      if (noisy) bus.start = 1'($urandom);
      tick();
      ec.push_back(cyc);
    end

    // FLUSH cycle: keep offering a junk word that must not be taken
    bus.ld_valid = 1'b1;
    bus.ld_last  = 1'b0;
    bus.ld_data  = $urandom;
    chk({tag, "_ready_after_last"}, 32'(bus.ld_ready), 0);
    chk({tag, "_busy_flush"}, 32'(bus.busy), 1);

    seen = 1'b0;
    for (int c = 0; c < total + 20 && !seen; c++) begin
      if (noisy) bus.start = 1'($urandom);
      tick();
      bus.ld_valid = 1'b0;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    bus.start    = 1'b0;
    bus.ld_valid = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 1);
    tick();

    chk({tag, "_busy_idle"}, 32'(bus.busy), 0);
    chk({tag, "_done_one_cycle"}, 32'(bus.done), 0);
    chk({tag, "_words"}, 32'(bus.words), 32'(n));
    chk({tag, "_write_count"}, 32'(wr_addr.size() - wb), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (wb + i < wr_addr.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[wb + i]), 32'(i));
        chk($sformatf("%s_data%0d", tag, i), wr_dat[wb + i], w[i]);
        chk($sformatf("%s_wcyc%0d", tag, i), 32'(wr_cyc[wb + i]), 32'(ec[i]));
      end
    end
    chk({tag, "_work_cycles"}, 32'(work_n - wnb), 32'(total));
    chk({tag, "_work_runs"}, 32'(runs - rb), 1);
    chk({tag, "_work_start"}, 32'(work_start), 32'(ec[n - 1] + 1));
    chk({tag, "_work_span"}, 32'(work_end - work_start + 1), 32'(total));
    chk({tag, "_done_count"}, 32'(done_n - db), 1);
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(ec[n - 1] + 1 + total));
    chk({tag, "_no_overlap"}, 32'(overlap_n), 0);
  endtask

  initial begin
    int wb, wnb, db;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;

    // reset overrides a simultaneous start
    rst_n     = 1'b0;
    bus.start = 1'b1;
    tick();
    tick();
    chk("rst_ld_ready", 32'(bus.ld_ready), 0);
    chk("rst_p_wEn", 32'(bus.p_wEn), 0);
    chk("rst_p_working", 32'(bus.p_working), 0);
    chk("rst_p_addr", 32'(bus.p_addr), 0);
    chk("rst_p_wDat", bus.p_wDat, 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_words", 32'(bus.words), 0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    tick();

    run_prog(3, 0, 0, 1'b1, 1'b0, "abc");
    run_prog(2, 3, 0, 1'b1, 1'b0, "gap3");
    run_prog(int'(DEPTH), 0, 0, 1'b0, 1'b0, "full");

    // abort in the 2nd RUN cycle of a 4-word program
    wb = wr_addr.size(); wnb = work_n; db = done_n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = $urandom;
      bus.ld_last  = (i == 3);
      tick();
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    tick();
    chk("abr_run1_working", 32'(bus.p_working), 1);
    tick();
    chk("abr_run2_working", 32'(bus.p_working), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abr_working_low", 32'(bus.p_working), 0);
    chk("abr_busy", 32'(bus.busy), 0);
    chk("abr_words", 32'(bus.words), 4);
    chk("abr_ready", 32'(bus.ld_ready), 0);
    repeat (3) tick();
    chk("abr_no_done", 32'(done_n - db), 0);
    chk("abr_work_cycles", 32'(work_n - wnb), 2);
    chk("abr_writes", 32'(wr_addr.size() - wb), 4);

    // abort is ignored in IDLE, then cancels a LOAD ahead of a same-edge word
    wb = wr_addr.size();
    bus.abort = 1'b1;
    tick();
    chk("idle_abort_busy", 32'(bus.busy), 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("idle_abort_start", 32'(bus.busy), 1);
    bus.ld_valid = 1'b1;
    bus.ld_data  = $urandom;
    tick();
    bus.ld_data = $urandom;
    bus.abort   = 1'b1;
    tick();
    bus.abort    = 1'b0;
    bus.ld_valid = 1'b0;
    chk("ldabr_wen", 32'(bus.p_wEn), 0);
    chk("ldabr_busy", 32'(bus.busy), 0);
    chk("ldabr_words", 32'(bus.words), 1);
    tick();
    chk("ldabr_writes", 32'(wr_addr.size() - wb), 1);

    // reset after 2 of 5 words, then reload from address 0
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = $urandom;
      tick();
    end
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.ld_data = $urandom;
    tick();
    chk("mrst_ld_ready", 32'(bus.ld_ready), 0);
    chk("mrst_p_wEn", 32'(bus.p_wEn), 0);
    chk("mrst_p_working", 32'(bus.p_working), 0);
    chk("mrst_p_addr", 32'(bus.p_addr), 0);
    chk("mrst_p_wDat", bus.p_wDat, 0);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_done", 32'(bus.done), 0);
    chk("mrst_words", 32'(bus.words), 0);
    rst_n        = 1'b1;
    bus.start    = 1'b0;
    bus.ld_valid = 1'b0;
    tick();
    run_prog(5, 0, 2, 1'b1, 1'b0, "reload");

    // random lengths and gaps with start toggling through LOAD and RUN
    for (int r = 0; r < 5; r++) begin
      run_prog(int'($urandom_range(12, 1)), 0, 3, 1'b1, 1'b1, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
